wfq_event_sequencer: RTL and testbench

//  Front-end controller for wfq_computation. Collects packet-arrival events from N ingress ports and

---
 rtl/wfq_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/wfq_event_sequencer.sv | 137 +++++++++++++
 tb/tb_wfq_event_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfq_pkg.sv
// Shared widths, FSM encoding and helpers for the WFQ event sequencer.
package wfq_pkg;
    localparam int FLOW_W  = 13;
    localparam int LEN_W   = 16;
    localparam int FTIME_W = 16;
    localparam int PORT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module rr_arbiter
    import wfq_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = found;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance && found)
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/wfq_event_sequencer.sv
// Serialises ingress arrivals and scheduler departures into the WFQ engine, one event in flight,
// and returns the engine's finish time tagged with the originating source.
module wfq_event_sequencer
    import wfq_pkg::*;
#(
    parameter int N_PORT      = 4,
    parameter int MAX_DEP_RUN = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORT-1:0]        arr_valid,
    output logic [N_PORT-1:0]        arr_ready,
    input  logic [N_PORT*FLOW_W-1:0] arr_flow_id,
    input  logic [N_PORT*LEN_W-1:0]  arr_len,
    input  logic                     dep_valid,
    output logic                     dep_ready,
    input  logic [FLOW_W-1:0]        dep_flow_id,
    input  logic [LEN_W-1:0]         dep_len,
    output logic                     wfq_arrival,
    output logic                     wfq_depart,
    output logic [FLOW_W-1:0]        wfq_flow_id,
    output logic [LEN_W-1:0]         wfq_packet_length,
    input  logic [FTIME_W-1:0]       wfq_oftime,
    input  logic                     wfq_odone,
    output logic                     res_valid,
    output logic [PORT_W-1:0]        res_port,
    output logic                     res_is_depart,
    output logic [FTIME_W-1:0]       res_ftime,
    output logic                     res_timeout,
    output logic                     err_stray,
    output logic                     busy
);
    localparam int PW = idx_w(N_PORT);
    localparam int RW = $clog2(MAX_DEP_RUN + 1);
    localparam int TW = idx_w(TIMEOUT_CYC);

    state_t          state;
    logic [N_PORT-1:0] rr_grant;
    logic [PW-1:0]   rr_idx;
    logic            ev_dep;
    logic [PW-1:0]   ev_port;
    logic [RW-1:0]   dep_run;
    logic [TW-1:0]   tmo_cnt;
    logic            idle, any_arr, arr_first, arr_take, dep_take;

    // Departures win unless they have starved pending arrivals for MAX_DEP_RUN grants.
    assign idle      = (state == S_IDLE) && !rst;
    assign any_arr   = |arr_valid;
    assign arr_first = any_arr && (!dep_valid || dep_run == RW'(MAX_DEP_RUN));
    assign dep_take  = idle && dep_valid && !arr_first;
    assign arr_take  = idle && arr_first;
    assign dep_ready = dep_take;
    assign arr_ready = arr_take ? rr_grant : '0;
    assign busy      = (state != S_IDLE);

    rr_arbiter #(.N(N_PORT)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (arr_valid),
        .advance  (arr_take),
        .grant    (rr_grant),
        .grant_idx(rr_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            ev_dep            <= 1'b0;
            ev_port           <= '0;
            dep_run           <= '0;
            tmo_cnt           <= '0;
            wfq_arrival       <= 1'b0;
            wfq_depart        <= 1'b0;
            wfq_flow_id       <= '0;
            wfq_packet_length <= '0;
            res_valid         <= 1'b0;
            res_port          <= '0;
            res_is_depart     <= 1'b0;
            res_ftime         <= '0;
            res_timeout       <= 1'b0;
            err_stray         <= 1'b0;
        end else begin
            wfq_arrival       <= 1'b0;
            wfq_depart        <= 1'b0;
            wfq_flow_id       <= '0;
            wfq_packet_length <= '0;
            res_valid         <= 1'b0;
            res_port          <= '0;
            res_is_depart     <= 1'b0;
            res_ftime         <= '0;
            res_timeout       <= 1'b0;
            if (wfq_odone && state != S_WAIT)
                err_stray <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (dep_take) begin
                        state             <= S_ISSUE;
                        wfq_depart        <= 1'b1;
                        wfq_flow_id       <= dep_flow_id;
                        wfq_packet_length <= dep_len;
                        ev_dep            <= 1'b1;
                        ev_port           <= '0;
                        if (any_arr)
                            dep_run <= dep_run + 1'b1;
                    end else if (arr_take) begin
                        state             <= S_ISSUE;
                        wfq_arrival       <= 1'b1;
                        wfq_flow_id       <= arr_flow_id[rr_idx*FLOW_W +: FLOW_W];
                        wfq_packet_length <= arr_len[rr_idx*LEN_W +: LEN_W];
                        ev_dep            <= 1'b0;
                        ev_port           <= rr_idx;
                        dep_run           <= '0;
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (wfq_odone || tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state         <= S_RESP;
                        res_valid     <= 1'b1;
                        res_port      <= PORT_W'(ev_port);
                        res_is_depart <= ev_dep;
                        res_ftime     <= wfq_odone ? wfq_oftime : '0;
                        res_timeout   <= !wfq_odone;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wfq_event_sequencer.sv
// Directed bench for wfq_event_sequencer: vector table of single events plus multi-cycle sequences.
module tb_wfq_event_sequencer;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    arr_valid = '0;
    logic [NP-1:0]    arr_ready;
    logic [NP*13-1:0] arr_flow_id = '0;
    logic [NP*16-1:0] arr_len = '0;
    logic             dep_valid = 1'b0;
    logic             dep_ready;
    logic [12:0]      dep_flow_id = '0;
    logic [15:0]      dep_len = '0;
    logic             wfq_arrival, wfq_depart;
    logic [12:0]      wfq_flow_id;
    logic [15:0]      wfq_packet_length;
    logic [15:0]      wfq_oftime = '0;
    logic             wfq_odone = 1'b0;
    logic             res_valid;
    logic [2:0]       res_port;
    logic             res_is_depart;
    logic [15:0]      res_ftime;
    logic             res_timeout, err_stray, busy;

    wfq_event_sequencer #(.N_PORT(NP), .MAX_DEP_RUN(4), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_flow_id(arr_flow_id), .arr_len(arr_len),
        .dep_valid(dep_valid), .dep_ready(dep_ready), .dep_flow_id(dep_flow_id), .dep_len(dep_len),
        .wfq_arrival(wfq_arrival), .wfq_depart(wfq_depart), .wfq_flow_id(wfq_flow_id),
        .wfq_packet_length(wfq_packet_length), .wfq_oftime(wfq_oftime), .wfq_odone(wfq_odone),
        .res_valid(res_valid), .res_port(res_port), .res_is_depart(res_is_depart),
        .res_ftime(res_ftime), .res_timeout(res_timeout), .err_stray(err_stray), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no DUT response within bound", nm);
    endtask

    // Engine model: answers eng_delay cycles after a pulse with eng_ftime; eng_delay 0 = silent.
    int          eng_delay = 2;
    int          eng_cnt = 0;
    logic [15:0] eng_ftime = '0;
    logic [15:0] eng_saved = '0;
    bit          eng_en = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (eng_en) begin
            wfq_odone  = 1'b0;
            wfq_oftime = '0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    wfq_odone  = 1'b1;
                    wfq_oftime = eng_saved;
                end
            end
            if (wfq_arrival || wfq_depart) begin
                eng_cnt   = eng_delay;
                eng_saved = eng_ftime;
            end
        end
    end

    // At most one event in flight: a second pulse before a result is an error.
    bit outstanding = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) outstanding = 1'b0;
        else begin
            if (wfq_arrival || wfq_depart) begin
                check("one_in_flight", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
            end
            if (res_valid) outstanding = 1'b0;
        end
    end

    task automatic wait_hs(input string nm, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((|arr_ready) || dep_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        if (!ok) fail_to(nm);
    endtask

    task automatic wait_pulse(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wfq_arrival || wfq_depart) ok = 1'b1;
        end
        if (!ok) fail_to(nm);
    endtask

    task automatic wait_res(input string nm, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        if (!ok) fail_to(nm);
    endtask

    typedef struct {
        logic        is_dep;
        int          port;
        logic [12:0] flow;
        logic [15:0] len;
        int          delay;
        logic [15:0] ftime;
        logic [2:0]  exp_port;
        logic        exp_tmo;
        logic [15:0] exp_ftime;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int k);
        bit ok;
        int t_hs, t_res;
        string s;
        s = $sformatf("v%0d", k);
        eng_delay = v.delay;
        eng_ftime = v.ftime;
        if (v.is_dep) begin
            dep_flow_id = v.flow;
            dep_len     = v.len;
            dep_valid   = 1'b1;
        end else begin
            arr_flow_id[13*v.port +: 13] = v.flow;
            arr_len[16*v.port +: 16]     = v.len;
            arr_valid[v.port]            = 1'b1;
        end
        wait_hs({s, "_hs"}, ok, t_hs);
        @(posedge clk); #1;
        arr_valid = '0;
        dep_valid = 1'b0;
        if (ok) begin
            @(negedge clk);
            check({s, "_arrival"}, 32'(wfq_arrival), 32'(!v.is_dep));
            check({s, "_depart"}, 32'(wfq_depart), 32'(v.is_dep));
            check({s, "_flow"}, 32'(wfq_flow_id), 32'(v.flow));
            check({s, "_len"}, 32'(wfq_packet_length), 32'(v.len));
            wait_res({s, "_res"}, ok, t_res);
            if (ok) begin
                check({s, "_lat"}, 32'(t_res - t_hs), 32'(v.exp_lat));
                check({s, "_port"}, 32'(res_port), 32'(v.exp_port));
                check({s, "_isdep"}, 32'(res_is_depart), 32'(v.is_dep));
                check({s, "_ftime"}, 32'(res_ftime), 32'(v.exp_ftime));
                check({s, "_tmo"}, 32'(res_timeout), 32'(v.exp_tmo));
                @(negedge clk);
                check({s, "_busy_after"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        bit ok;
        int t;
        int ord[5];
        int nres;
        ord = '{0, 1, 2, 3, 0};

        //            dep  port flow      len       dly ftime     eport tmo eftime    lat
        vecs[0] = '{1'b0, 2, 13'h0002, 16'h000C, 2, 16'h000C, 3'd2, 1'b0, 16'h000C, 4};
        vecs[1] = '{1'b0, 0, 13'h1FFF, 16'hFFFF, 1, 16'hABCD, 3'd0, 1'b0, 16'hABCD, 3};
        vecs[2] = '{1'b0, 1, 13'h0005, 16'h0000, 5, 16'h0042, 3'd1, 1'b0, 16'h0042, 7};
        vecs[3] = '{1'b1, 0, 13'h0777, 16'h0300, 3, 16'h1234, 3'd0, 1'b0, 16'h1234, 5};
        vecs[4] = '{1'b0, 3, 13'h1000, 16'h8001, 2, 16'hFFFF, 3'd3, 1'b0, 16'hFFFF, 4};
        vecs[5] = '{1'b1, 0, 13'h0001, 16'h0040, 0, 16'h5A5A, 3'd0, 1'b1, 16'h0000, 66};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_arr_ready", 32'(arr_ready), 32'd0);
        check("rst_dep_ready", 32'(dep_ready), 32'd0);
        check("rst_pulses", 32'({wfq_arrival, wfq_depart}), 32'd0);
        check("rst_wfq_data", 32'({wfq_flow_id, wfq_packet_length}), 32'd0);
        check("rst_res", 32'({res_valid, res_port, res_is_depart, res_timeout}), 32'd0);
        check("rst_res_ftime", 32'(res_ftime), 32'd0);
        check("rst_err_busy", 32'({err_stray, busy}), 32'd0);

        // Single-event vectors (includes len 0, max flow/len, depart and timeout)
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            run_vec(vecs[k], k);
        end
        check("no_stray_yet", 32'(err_stray), 32'd0);

        // All four ports continuously valid: round robin 0,1,2,3,0
        @(posedge clk); #1;
        for (int i = 0; i < NP; i++) begin
            arr_flow_id[13*i +: 13] = 13'(16 + i);
            arr_len[16*i +: 16]     = 16'(256 + i);
        end
        eng_delay = 1;
        eng_ftime = 16'h0200;
        arr_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_pulse($sformatf("rr_pulse%0d", k), ok);
            if (ok) begin
                check($sformatf("rr_flow%0d", k), 32'(wfq_flow_id), 32'(16 + ord[k]));
                check($sformatf("rr_len%0d", k), 32'(wfq_packet_length), 32'(256 + ord[k]));
            end
            if (k == 4) arr_valid = '0;
            wait_res($sformatf("rr_res%0d", k), ok, t);
            if (ok) check($sformatf("rr_port%0d", k), 32'(res_port), 32'(ord[k]));
        end

        // Depart and port 1 in the same cycle: depart first
        @(posedge clk); #1;
        arr_flow_id[13 +: 13] = 13'h0111;
        arr_len[16 +: 16]     = 16'h0011;
        dep_flow_id = 13'h0999;
        dep_len     = 16'h0099;
        dep_valid   = 1'b1;
        arr_valid   = 4'b0010;
        @(negedge clk);
        check("prio_dep_ready", 32'(dep_ready), 32'd1);
        check("prio_arr_ready", 32'(arr_ready), 32'd0);
        @(posedge clk); #1;
        dep_valid = 1'b0;
        wait_pulse("prio_p0", ok);
        if (ok) check("prio_first_dep", 32'({wfq_depart, wfq_flow_id}), 32'({1'b1, 13'h0999}));
        wait_pulse("prio_p1", ok);
        if (ok) check("prio_then_arr", 32'({wfq_arrival, wfq_flow_id}), 32'({1'b1, 13'h0111}));
        arr_valid = '0;
        wait_res("prio_res", ok, t);
        if (ok) check("prio_res_port", 32'(res_port), 32'd1);

        // Continuous departs with port 0 pending: port 0 after exactly 4 departs
        @(posedge clk); #1;
        arr_flow_id[0 +: 13] = 13'h0AAA;
        arr_valid = 4'b0001;
        dep_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_pulse($sformatf("run_p%0d", k), ok);
            if (ok) check($sformatf("run_kind%0d", k), 32'(wfq_depart), 32'(k < 4));
            if (k == 4) begin
                if (ok) check("run_arr_flow", 32'(wfq_flow_id), 32'h0AAA);
                arr_valid = '0;
                dep_valid = 1'b0;
            end
        end
        wait_res("run_res", ok, t);
        if (ok) check("run_res_port", 32'({res_is_depart, res_port}), 32'd0);

        // Stall: port 3 held while a slow depart is in flight
        @(posedge clk); #1;
        dep_flow_id = 13'h0333;
        dep_len     = 16'h0033;
        dep_valid   = 1'b1;
        eng_delay   = 12;
        eng_ftime   = 16'h0E0E;
        wait_hs("stall_hs", ok, t);
        @(posedge clk); #1;
        dep_valid = 1'b0;
        arr_flow_id[39 +: 13] = 13'h0ABC;
        arr_len[48 +: 16]     = 16'h5555;
        arr_valid = 4'b1000;
        nres = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (arr_ready != '0) nres++;
        end
        check("stall_ready_low", 32'(nres), 32'd0);
        wait_pulse("stall_pulse", ok);
        if (ok) begin
            check("stall_kind", 32'(wfq_arrival), 32'd1);
            check("stall_flow", 32'(wfq_flow_id), 32'h0ABC);
            check("stall_len", 32'(wfq_packet_length), 32'h5555);
        end
        arr_valid = '0;
        wait_res("stall_res", ok, t);
        if (ok) check("stall_res", 32'({res_port, res_ftime}), 32'({3'd3, 16'h0E0E}));

        // Reset during WAIT drops the event; later odone in IDLE is stray
        @(posedge clk); #1;
        arr_flow_id[26 +: 13] = 13'h0222;
        arr_valid = 4'b0100;
        eng_delay = 0;
        wait_pulse("mid_rst_pulse", ok);
        arr_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_res", 32'({res_valid, res_port, res_timeout, res_ftime}), 32'd0);
        check("mrst_wfq", 32'({wfq_arrival, wfq_depart, wfq_flow_id}), 32'd0);
        check("mrst_ready", 32'({arr_ready, dep_ready}), 32'd0);
        nres = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) nres++;
        end
        check("mrst_no_result", 32'(nres), 32'd0);
        check("mrst_stray_clear", 32'(err_stray), 32'd0);
        eng_en = 1'b0;
        @(posedge clk); #1;
        wfq_odone  = 1'b1;
        wfq_oftime = 16'h7777;
        @(posedge clk); #1;
        wfq_odone  = 1'b0;
        @(negedge clk);
        check("stray_set", 32'(err_stray), 32'd1);
        check("stray_no_res", 32'({res_valid, busy}), 32'd0);
        repeat (3) @(negedge clk);
        check("stray_sticky", 32'(err_stray), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
